// File: rtl/uart_fifo_transmitter.sv
// uart_fifo_transmitter: byte FIFO feeding an 8N1 UART transmitter.
//   Clock       - system clock, rising edge active
//   Reset       - asynchronous active-low reset
//   DataIn      - byte offered for transmission
//   DataInValid - DataIn holds a valid byte
//   DataInReady - FIFO can accept a byte this cycle (combinational)
//   SOut        - registered serial line, idles high
//   Busy        - frame in flight or FIFO not empty
//   Count       - number of occupied FIFO entries
module uart_fifo_transmitter #(
  parameter int unsigned ClockFreq = 50_000_000,
  parameter int unsigned BaudRate  = 115_200,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [7:0]                 DataIn,
  input  logic                       DataInValid,
  output logic                       DataInReady,
  output logic                       SOut,
  output logic                       Busy,
  output logic [$clog2(FifoDepth):0] Count
);

  localparam int unsigned SymbolEdge = ClockFreq / BaudRate;
  localparam int unsigned AddrW      = $clog2(FifoDepth);
  localparam int unsigned CycW       = (SymbolEdge > 1) ? $clog2(SymbolEdge) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(SymbolEdge - 1);
  localparam logic [AddrW:0]  Full    = (AddrW + 1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [FifoDepth];
  logic [AddrW-1:0] wr_ptr;
  logic [AddrW-1:0] rd_ptr;
  logic [AddrW:0]   count;
  logic [7:0]       shift;
  logic [2:0]       bit_idx;
  logic [CycW-1:0]  cyc;
  logic             sout_q;
  logic             push;
  logic             pop;
  logic             cyc_last;

  assign cyc_last    = (cyc == CycLast);
  assign DataInReady = Reset && (count < Full);
  assign push        = DataInValid && DataInReady;
  // A pop happens from IDLE, or on the last stop-bit cycle so frames run back to back.
  assign pop         = (count != '0) &&
                       ((state == IDLE) || ((state == STOP) && cyc_last));
  assign SOut        = sout_q;
  assign Busy        = (state != IDLE) || (count != '0);
  assign Count       = count;

  always_ff @(posedge Clock) begin
    if (push) begin
      mem[wr_ptr] <= DataIn;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AddrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AddrW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AddrW + 1)'(1);
        2'b01:   count <= count - (AddrW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      sout_q  <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      cyc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          sout_q <= 1'b1;
          if (pop) begin
            shift  <= mem[rd_ptr];
            cyc    <= '0;
            sout_q <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (cyc_last) begin
            cyc     <= '0;
            bit_idx <= '0;
            sout_q  <= shift[0];
            state   <= DATA;
          end else begin
            cyc <= cyc + CycW'(1);
          end
        end
        DATA: begin
          if (cyc_last) begin
            cyc <= '0;
            if (bit_idx == 3'd7) begin
              sout_q <= 1'b1;
              state  <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              sout_q  <= shift[bit_idx + 3'd1];
            end
          end else begin
            cyc <= cyc + CycW'(1);
          end
        end
        STOP: begin
          if (cyc_last) begin
            cyc <= '0;
            if (pop) begin
              shift  <= mem[rd_ptr];
              sout_q <= 1'b0;
              state  <= START;
            end else begin
              sout_q <= 1'b1;
              state  <= IDLE;
            end
          end else begin
            cyc <= cyc + CycW'(1);
          end
        end
        default: begin
          sout_q <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Directed bench for uart_fifo_transmitter with SymbolEdge = 10, FifoDepth = 4.
module tb_uart_fifo_transmitter;

  logic       Clock;
  logic       Reset;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SOut;
  logic       Busy;
  logic [2:0] Count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  uart_fifo_transmitter #(
    .ClockFreq(100),
    .BaudRate (10),
    .FifoDepth(4)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .DataIn     (DataIn),
    .DataInValid(DataInValid),
    .DataInReady(DataInReady),
    .SOut       (SOut),
    .Busy       (Busy),
    .Count      (Count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    DataIn      = b;
    DataInValid = 1'b1;
    tick();
    DataInValid = 1'b0;
  endtask

  // Expected line level at position pos (0..99) of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int pos);
    int slot;
    slot = pos / 10;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  // Called just after the edge that starts the first frame.
  task automatic check_stream(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input int nframes);
    for (int j = 0; j < 100 * nframes; j++) begin
      check(tag, SOut, exp_bit((j < 100) ? b0 : b1, j % 100));
      tick();
    end
    check({tag, "_busy_end"}, Busy, 1'b0);
    check({tag, "_sout_end"}, SOut, 1'b1);
  endtask

  initial begin
    logic [7:0] full_bytes [6];
    logic [7:0] b;
    int         idx;
    int         acc6;
    logic       rdy;

    Reset       = 1'b0;
    DataIn      = 8'h00;
    DataInValid = 1'b0;

    // Reset state and release
    tick();
    tick();
    check("rst_sout",  SOut,        1'b1);
    check("rst_rdy",   DataInReady, 1'b0);
    check("rst_busy",  Busy,        1'b0);
    check("rst_count", Count,       3'd0);
    Reset = 1'b1;
    #1;
    check("rel_rdy",  DataInReady, 1'b1);
    check("rel_sout", SOut,        1'b1);
    tick();
    tick();
    check("rel_sout2", SOut, 1'b1);
    check("rel_busy",  Busy, 1'b0);

    // DataIn ignored while DataInValid is low
    for (int i = 0; i < 50; i++) begin
      DataIn = 8'($urandom);
      tick();
      check("vlow_count", Count, 3'd0);
      check("vlow_sout",  SOut,  1'b1);
    end

    // Single byte 0xA5: pushed at edge N, start bit from N+1
    push_byte(8'hA5);
    check("single_lat_sout", SOut,  1'b1);
    check("single_count",    Count, 3'd1);
    check("single_busy",     Busy,  1'b1);
    tick();
    check("single_count0", Count, 3'd0);
    check_stream("single_sout", 8'hA5, 8'h00, 1);

    // Full FIFO with 0x01..0x06 held on DataIn
    for (int i = 0; i < 6; i++) full_bytes[i] = 8'(i + 1);
    DataIn      = full_bytes[0];
    DataInValid = 1'b1;
    check("full_rdy0", DataInReady, 1'b1);
    tick();
    idx    = 1;
    DataIn = full_bytes[1];
    acc6   = -1;
    for (int j = 0; j <= 600; j++) begin
      rdy = DataInReady;
      tick();
      if (DataInValid && rdy) begin
        if (idx == 5) acc6 = j;
        idx++;
        if (idx == 6) DataInValid = 1'b0;
        else DataIn = full_bytes[idx];
      end
      if (j < 600) begin
        b = full_bytes[j / 100];
        check("full_sout", SOut, exp_bit(b, j % 100));
      end
      if (j == 3) begin
        check("full_count4", Count,       3'd4);
        check("full_rdy_lo", DataInReady, 1'b0);
      end
      if (j == 99) check("full_still4", Count, 3'd4);
      if (j == 600) begin
        check("full_busy_end", Busy,  1'b0);
        check("full_cnt_end",  Count, 3'd0);
      end
    end
    check("full_acc6_edge", acc6, 101);
    DataInValid = 1'b0;

    // Simultaneous push/pop on the STOP-final edge
    push_byte(8'h11);
    for (int i = 0; i < 4; i++) tick();
    push_byte(8'h22);
    check("simul_cnt1", Count, 3'd1);
    for (int i = 0; i < 95; i++) tick();
    DataIn      = 8'h33;
    DataInValid = 1'b1;
    check("simul_rdy", DataInReady, 1'b1);
    tick();
    DataInValid = 1'b0;
    check("simul_cnt_same", Count, 3'd1);
    check_stream("simul_sout", 8'h22, 8'h33, 2);

    // Reset during DATA bit 3 of 0x3C with two bytes queued
    push_byte(8'h3C);
    tick();
    push_byte(8'hAA);
    push_byte(8'h55);
    check("rmid_cnt2", Count, 3'd2);
    for (int i = 0; i < 42; i++) tick();
    check("rmid_bit3", SOut, 1'b1);
    check("rmid_busy", Busy, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check("rmid_sout",  SOut,        1'b1);
    check("rmid_count", Count,       3'd0);
    check("rmid_busy0", Busy,        1'b0);
    check("rmid_rdy",   DataInReady, 1'b0);
    tick();
    tick();
    #2 Reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      check("rmid_post_sout", SOut,  1'b1);
      check("rmid_post_busy", Busy,  1'b0);
    end
    check("rmid_post_rdy", DataInReady, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_transmitter.md
UART_FIFO_TRANSMITTER -- requirements
Module: uart_fifo_transmitter

Interface
REQ-001 The block SHALL have parameter ClockFreq, default 50_000_000, the Clock frequency in Hz.
REQ-002 The block SHALL have parameter BaudRate, default 115_200, the serial bit rate in bits per second.
REQ-003 The block SHALL have parameter FifoDepth, default 4, the number of byte entries in the transmit FIFO; it SHALL be a power of two and at least 2.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Clock  input  1  system clock; all state changes on its rising edge, except reset.
REQ-006 Reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-007 DataIn  input  8  byte offered for transmission.
REQ-008 DataInValid  input  1  DataIn holds a valid byte.
REQ-009 DataInReady  output  1  FIFO can accept a byte this cycle.
REQ-010 SOut  output  1  serial line; idles high.
REQ-011 Busy  output  1  frame in flight or FIFO not empty.
REQ-012 Count  output  $clog2(FifoDepth)+1  number of FIFO entries occupied.

Function
REQ-013 The bit period SHALL be SymbolEdge = ClockFreq/BaudRate Clock cycles, integer division, truncated.
REQ-014 A push SHALL occur on a rising edge where DataInValid && DataInReady; DataIn is written at the FIFO tail and Count increments.
REQ-015 DataInReady SHALL be combinational: 1 when Count < FifoDepth and Reset is high, else 0; a same-edge pop SHALL NOT raise DataInReady while full (no bypass).
REQ-016 When DataInValid is 0, DataIn SHALL be ignored.
REQ-017 The FIFO SHALL use wrapping read and write pointers; a simultaneous push and pop SHALL leave Count unchanged and preserve order.
REQ-018 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-019 IDLE: SOut=1; on an edge where Count != 0, pop the head into the shift register, clear the cycle counter and go to START.
REQ-020 START: SOut=0 for SymbolEdge cycles, then go to DATA with bit index 0.
REQ-021 DATA: SOut = shift[bit index], LSB first, each bit for SymbolEdge cycles; after bit 7 go to STOP.
REQ-022 STOP: SOut=1 for SymbolEdge cycles; at the final cycle, if Count != 0, pop and go directly to START (no idle gap), else go to IDLE.
REQ-023 SOut SHALL be registered, with no glitches.
REQ-024 Latency: a byte pushed into an empty FIFO at edge N while in IDLE SHALL cause SOut to fall after edge N+1.
REQ-025 A full frame SHALL be exactly 10*SymbolEdge cycles.
REQ-026 Busy SHALL be (state != IDLE) || (Count != 0).
REQ-027 A push arriving while a frame is in progress SHALL not disturb the frame in flight.

Reset
REQ-028 While Reset=0, the outputs SHALL be SOut=1, DataInReady=0, Busy=0, Count=0, and the state SHALL be IDLE, asynchronously.
REQ-029 Reset asserted mid-frame SHALL abandon the frame, drive SOut to 1 immediately and discard all FIFO contents.
REQ-030 After Reset deasserts, no frame SHALL start until a new push occurs.

Verification (ClockFreq=100, BaudRate=10, so SymbolEdge=10, FifoDepth=4)
REQ-031 Reset: drive Reset=0 -> SOut=1, DataInReady=0, Busy=0, Count=0; release Reset -> DataInReady=1 on the same cycle, SOut stays 1.
REQ-032 Single byte: push 0xA5 at edge N -> SOut=0 over cycles N+1..N+10, then 1,0,1,0,0,1,0,1 for 10 cycles each, then stop bit 1 for 10 cycles; Busy falls after edge N+101.
REQ-033 Full FIFO: hold DataInValid with bytes 0x01..0x06 -> 0x01..0x05 accepted on consecutive edges, then DataInReady=0 with Count=4; 0x06 is accepted only after the second pop; six frames back-to-back with no idle gap, in order, 600 cycles total.
REQ-034 Simultaneous push/pop: with Count=1, push on the STOP-final edge -> Count stays 1, and the next frame carries the older byte.
REQ-035 Reset mid-frame: assert Reset during DATA bit 3 of 0x3C with 2 bytes queued -> SOut=1 immediately, Count=0; after release, SOut stays 1 and Busy stays 0 for 200 cycles.
REQ-036 Valid low: toggle DataIn for 50 cycles with DataInValid=0 -> Count=0, SOut=1 throughout.
